// File: rtl/phosphor_pkg.sv
// Shared types and helpers for the phosphor decay writer.
package phosphor_pkg;

  // Intensity width; has to match the line buffer data width.
  localparam int unsigned PIXEL_W = 8;

  // Startup sequencer states. The encoding is fixed so it can be matched against
  // other tools that inspect the state register.
  typedef enum logic [1:0] {
    StWaitFrame = 2'd0,
    StClear     = 2'd1,
    StRun       = 2'd2
  } state_e;

  // Unsigned add clamped to full scale.
  function automatic logic [PIXEL_W-1:0] sat_add(input logic [PIXEL_W-1:0] a,
                                                 input logic [PIXEL_W-1:0] b);
    logic [PIXEL_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[PIXEL_W] ? {PIXEL_W{1'b1}} : sum[PIXEL_W-1:0];
  endfunction

  // Larger of two intensities.
  function automatic logic [PIXEL_W-1:0] max_px(input logic [PIXEL_W-1:0] a,
                                                input logic [PIXEL_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/phosphor_decay_alu.sv
// Combinational decay + hit merge datapath.
// Build option: PHOSPHOR_ADDITIVE_HIT_EN selects a saturating additive merge
// instead of the default max() merge.
module phosphor_decay_alu
  import phosphor_pkg::*;
#(
  parameter int unsigned DECAY_SHIFT = 3
) (
  input  logic [PIXEL_W-1:0] tap,
  input  logic               decay_frame,
  input  logic               hit_valid,
  input  logic [PIXEL_W-1:0] hit_intensity,
  output logic [PIXEL_W-1:0] result
);

  logic [PIXEL_W:0]   tap_w;
  logic [PIXEL_W:0]   step_w;
  logic [PIXEL_W:0]   decay_w;
  logic [PIXEL_W-1:0] d;

  // Decay by tap >> DECAY_SHIFT with a minimum step of one so dim pixels still fade out.
  always_comb begin
    tap_w  = {1'b0, tap};
    step_w = tap_w >> DECAY_SHIFT;
    if (step_w == '0) begin
      step_w = {{PIXEL_W{1'b0}}, 1'b1};
    end
    decay_w = tap_w;
    if (decay_frame && (tap != '0)) begin
      decay_w = tap_w - step_w;
    end
    // A borrow would show up in the extra bit; clamp it to black.
    d = decay_w[PIXEL_W] ? '0 : decay_w[PIXEL_W-1:0];
  end

  // Merge the beam hit into the decayed value.
  always_comb begin
    result = d;
    if (hit_valid) begin
`ifdef PHOSPHOR_ADDITIVE_HIT_EN
      result = sat_add(d, hit_intensity);
`else
      result = max_px(d, hit_intensity);
`endif
    end
  end

endmodule

// File: rtl/phosphor_decay_writer.sv
// Write side of the one-line phosphor delay loop: decays the previous line's pixel,
// merges beam hits and feeds the result back to the buffer and the mixer.
// Fixed 2-clock latency. Build option: PHOSPHOR_ADDITIVE_HIT_EN (see phosphor_decay_alu).
module phosphor_decay_writer
  import phosphor_pkg::*;
#(
  parameter int unsigned DECAY_SHIFT  = 3,
  parameter int unsigned DECAY_PERIOD = 2   // 1..15
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               frame_start,
  input  logic               active,
  input  logic [PIXEL_W-1:0] tap_in,
  input  logic               hit_valid,
  input  logic [PIXEL_W-1:0] hit_intensity,
  output logic [PIXEL_W-1:0] shiftin_out,
  output logic [PIXEL_W-1:0] pixel_out,
  output logic               pixel_out_valid
);

  state_e state_q, state_d;
  logic   run_mode;

  logic [3:0] fcnt_q, fcnt_d;

  // Stage 1 registers.
  logic [PIXEL_W-1:0] tap_q;
  logic               active_q;
  logic               hit_valid_q;
  logic [PIXEL_W-1:0] hit_int_q;
  logic               decay_frame_q;
  logic               run_q;

  // Stage 2 registers.
  logic [PIXEL_W-1:0] out_q, out_d;
  logic               valid_q;

  logic [PIXEL_W-1:0] alu_result;

  // Frame counter: advances modulo DECAY_PERIOD on each frame_start.
  always_comb begin
    fcnt_d = fcnt_q;
    if (frame_start) begin
      fcnt_d = (fcnt_q >= 4'(DECAY_PERIOD - 1)) ? 4'd0 : fcnt_q + 4'd1;
    end
  end

  // Frame counter register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fcnt_q <= 4'd0;
    end else begin
      fcnt_q <= fcnt_d;
    end
  end

  // Startup sequencer state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StWaitFrame;
    end else begin
      state_q <= state_d;
    end
  end

  // Startup sequencer next state: one full frame of clearing before normal running.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWaitFrame: if (frame_start) state_d = StClear;
      StClear:     if (frame_start) state_d = StRun;
      StRun:       state_d = StRun;
      default:     state_d = StWaitFrame;
    endcase
  end

  // Startup sequencer output: only RUN lets real data through.
  always_comb begin
    run_mode = (state_q == StRun);
  end

  // Stage 1: capture inputs together with the frame rule and mode that apply to them,
  // so a frame_start cycle still sees the previous frame's settings.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tap_q         <= '0;
      active_q      <= 1'b0;
      hit_valid_q   <= 1'b0;
      hit_int_q     <= '0;
      decay_frame_q <= 1'b0;
      run_q         <= 1'b0;
    end else begin
      tap_q         <= tap_in;
      active_q      <= active;
      hit_valid_q   <= hit_valid;
      hit_int_q     <= hit_intensity;
      decay_frame_q <= (fcnt_q == 4'd0);
      run_q         <= run_mode;
    end
  end

  phosphor_decay_alu #(
    .DECAY_SHIFT (DECAY_SHIFT)
  ) u_alu (
    .tap           (tap_q),
    .decay_frame   (decay_frame_q),
    .hit_valid     (hit_valid_q),
    .hit_intensity (hit_int_q),
    .result        (alu_result)
  );

  // Blanked slots and the startup flush both write black into the buffer.
  always_comb begin
    out_d = (active_q && run_q) ? alu_result : '0;
  end

  // Stage 2 output register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= active_q;
    end
  end

  assign shiftin_out     = out_q;
  assign pixel_out       = out_q;
  assign pixel_out_valid = valid_q;

endmodule

// File: tb/tb_phosphor_decay_writer.sv
// Self-checking bench for phosphor_decay_writer: directed table, startup/reset
// sequences and randomized traffic against a frame-counting reference model.
module tb_phosphor_decay_writer;

  localparam int DecayShift  = 3;
  localparam int DecayPeriod = 2;

  logic       clock         = 1'b0;
  logic       reset_n       = 1'b0;
  logic       frame_start   = 1'b0;
  logic       active        = 1'b0;
  logic [7:0] tap_in        = 8'h00;
  logic       hit_valid     = 1'b0;
  logic [7:0] hit_intensity = 8'h00;
  logic [7:0] shiftin_out;
  logic [7:0] pixel_out;
  logic       pixel_out_valid;

  phosphor_decay_writer #(
    .DECAY_SHIFT  (DecayShift),
    .DECAY_PERIOD (DecayPeriod)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .frame_start     (frame_start),
    .active          (active),
    .tap_in          (tap_in),
    .hit_valid       (hit_valid),
    .hit_intensity   (hit_intensity),
    .shiftin_out     (shiftin_out),
    .pixel_out       (pixel_out),
    .pixel_out_valid (pixel_out_valid)
  );

  initial forever #5 clock = ~clock;

  typedef struct {
    logic [7:0] px;
    logic       valid;
    logic       chk_valid;
    string      name;
  } exp_t;

  typedef struct {
    logic       fs;
    logic       act;
    logic [7:0] tap;
    logic       hv;
    logic [7:0] hi;
    logic [7:0] exp_px;
    string      name;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[$];
  int   vectors      = 0;
  int   miscompares  = 0;
  int   frames_seen  = 0;  // frame_start pulses since the last reset

  // Reference: flushing lasts two frame_starts, decay on every DecayPeriod-th frame.
  function automatic logic [7:0] ref_px(input logic act, input logic [7:0] tap,
                                        input logic hv, input logic [7:0] hi, input int frames);
    int d;
    int step;
    if (frames < 2 || !act) return 8'h00;
    d = tap;
    if ((frames % DecayPeriod) == 0 && tap != 0) begin
      step = int'(tap) / (1 << DecayShift);
      if (step < 1) step = 1;
      d = d - step;
    end
    if (hv) begin
`ifdef PHOSPHOR_ADDITIVE_HIT_EN
      d = d + int'(hi);
      if (d > 255) d = 255;
`else
      if (int'(hi) > d) d = hi;
`endif
    end
    return 8'(d);
  endfunction

  // Apply one input cycle; compare the output that belongs to the previous cycle's input.
  task automatic cycle(input logic fs, input logic act, input logic [7:0] tap, input logic hv,
                       input logic [7:0] hi, input logic [7:0] exp_px, input string name);
    exp_t e;
    frame_start   = fs;
    active        = act;
    tap_in        = tap;
    hit_valid     = hv;
    hit_intensity = hi;
    e.px        = exp_px;
    e.valid     = act;
    e.chk_valid = (frames_seen >= 2);
    e.name      = name;
    exp_q.push_back(e);
    @(posedge clock);
    if (fs) frames_seen++;
    #1;
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      vectors++;
      if (shiftin_out !== e.px || pixel_out !== e.px ||
          (e.chk_valid && pixel_out_valid !== e.valid)) begin
        miscompares++;
        $display("FAIL %s: shiftin_out=%h pixel_out=%h valid=%b, required px=%h valid=%b",
                 e.name, shiftin_out, pixel_out, pixel_out_valid, e.px, e.valid);
      end
    end
  endtask

  task automatic check_zero(input string name);
    vectors++;
    if (shiftin_out !== 8'h00 || pixel_out !== 8'h00 || pixel_out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: shiftin_out=%h pixel_out=%h valid=%b, required all zero",
               name, shiftin_out, pixel_out, pixel_out_valid);
    end
  endtask

  // Walk through WAIT_FRAME and CLEAR with bright data that must be flushed to zero.
  task automatic startup(input string tag);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'hFF, 1'b1, 8'hFF, 8'h00, {tag, "_wait"});
    cycle(1'b1, 1'b1, 8'hFF, 1'b0, 8'h00, 8'h00, {tag, "_wait_fs"});
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'hFF, 1'b1, 8'h33, 8'h00, {tag, "_clear"});
    cycle(1'b1, 1'b1, 8'hC0, 1'b0, 8'h00, 8'h00, {tag, "_clear_fs"});
    cycle(1'b0, 1'b1, 8'h80, 1'b0, 8'h00, 8'h70, {tag, "_first_run"});
  endtask

  initial begin
    logic       fs, act, hv;
    logic [7:0] tap, hi;

    // Directed table, applied starting on an even (decay) frame in RUN.
    tbl.push_back('{1'b0, 1'b1, 8'h05, 1'b0, 8'h00, 8'h04, "floor_05"});
    tbl.push_back('{1'b0, 1'b1, 8'h01, 1'b0, 8'h00, 8'h00, "floor_01"});
    tbl.push_back('{1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, "floor_00"});
    tbl.push_back('{1'b0, 1'b1, 8'h40, 1'b1, 8'h00, 8'h38, "hit_zero"});
`ifdef PHOSPHOR_ADDITIVE_HIT_EN
    tbl.push_back('{1'b0, 1'b1, 8'hA0, 1'b1, 8'h90, 8'hFF, "add_sat"});
    tbl.push_back('{1'b0, 1'b1, 8'h00, 1'b1, 8'h10, 8'h10, "add_dark"});
`else
    tbl.push_back('{1'b0, 1'b1, 8'h20, 1'b1, 8'h90, 8'h90, "max_hit_wins"});
    tbl.push_back('{1'b0, 1'b1, 8'hA0, 1'b1, 8'h50, 8'h8C, "max_decay_wins"});
`endif
    tbl.push_back('{1'b0, 1'b0, 8'hFF, 1'b1, 8'hFF, 8'h00, "blank"});
    tbl.push_back('{1'b1, 1'b1, 8'h40, 1'b0, 8'h00, 8'h38, "fs_even_rule"});
    tbl.push_back('{1'b0, 1'b1, 8'h40, 1'b0, 8'h00, 8'h40, "odd_frame"});
`ifdef PHOSPHOR_ADDITIVE_HIT_EN
    tbl.push_back('{1'b0, 1'b1, 8'h40, 1'b1, 8'h20, 8'h60, "odd_add"});
`else
    tbl.push_back('{1'b0, 1'b1, 8'h40, 1'b1, 8'h20, 8'h40, "odd_max"});
`endif
    tbl.push_back('{1'b1, 1'b1, 8'h40, 1'b0, 8'h00, 8'h40, "fs_odd_rule"});
    tbl.push_back('{1'b0, 1'b1, 8'h40, 1'b0, 8'h00, 8'h38, "even_frame"});

    // Reset state.
    repeat (3) @(posedge clock);
    #1;
    check_zero("reset_state");
    reset_n = 1'b1;

    startup("boot");

    foreach (tbl[i]) begin
      cycle(tbl[i].fs, tbl[i].act, tbl[i].tap, tbl[i].hv, tbl[i].hi, tbl[i].exp_px, tbl[i].name);
    end

    // Randomized traffic in RUN.
    for (int i = 0; i < 400; i++) begin
      fs  = ($urandom_range(0, 39) == 0);
      act = ($urandom_range(0, 3) != 0);
      tap = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 9)) : 8'($urandom_range(0, 255));
      hv  = ($urandom_range(0, 2) == 0);
      hi  = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      cycle(fs, act, tap, hv, hi, ref_px(act, tap, hv, hi, frames_seen), "random");
    end

    // Mid-line reset with bright data in flight.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 8'hFF, 1'b0, 8'h00,
            ref_px(1'b1, 8'hFF, 1'b0, 8'h00, frames_seen), "pre_reset");
    end
    #2;
    reset_n = 1'b0;
    #1;
    check_zero("midline_reset");
    exp_q.delete();
    frames_seen = 0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Must go through the whole flush again.
    startup("reboot");
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, "drain");
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, "drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/phosphor_decay_writer.md
Name: phosphor_decay_writer

Overview:
- Write-side partner of the one-line-delay phosphor buffer. The buffer's delayed tap of the previous line's pixel comes back into this block.
- Each clock, the block:
  - decays that pixel's intensity,
  - merges in new beam hits,
  - drives the result back into the buffer input and to the video mixer.
- Sits between the beam/pixel-hit logic and the line delay buffer, in the `clock` domain of the 1024x768@50Hz video pipeline.

Parameters:
- PIXEL_W, 8, intensity width; must equal the line buffer data width.
- DECAY_SHIFT, 3, decay step = intensity >> DECAY_SHIFT (minimum step 1).
- DECAY_PERIOD, 2, decay applied on one frame out of every DECAY_PERIOD frames (range 1..15).

Ports:
- clock, in, 1, pixel clock.
- reset_n, in, 1, asynchronous active-low reset.
- frame_start, in, 1, one-clock pulse at the first clock of each frame.
- active, in, 1, high during visible pixels.
- tap_in, in, PIXEL_W, delayed pixel from the line buffer taps output.
- hit_valid, in, 1, beam hit on the current pixel.
- hit_intensity, in, PIXEL_W, intensity of the hit.
- shiftin_out, out, PIXEL_W, value written into the line buffer input.
- pixel_out, out, PIXEL_W, same value, for display.
- pixel_out_valid, out, 1, `active` delayed to align with pixel_out.

Behaviour:
- Free-running stream: one value is produced every clock. There is no stall or backpressure, because the line buffer advances every clock.
- Fixed latency of 2 clocks from {tap_in, active, hit_*} to {shiftin_out, pixel_out, pixel_out_valid}. The external loop length relies on exactly 2, so it must not vary.
- Stage 1: register tap_in, active, hit_valid and hit_intensity.
- Stage 2, decay value d:
  - Decay frame with tap != 0: d = tap − max(tap >> DECAY_SHIFT, 1).
  - Otherwise: d = tap.
  - d never underflows below 0.
- Merge: out = hit_valid ? max(d, hit_intensity) : d.
- Blanking: when stage-1 active = 0, out = 0 regardless of hit. This scrubs off-screen slots.
- Frame counter `fcnt` (4 bit):
  - On frame_start, fcnt increments modulo DECAY_PERIOD.
  - decay_frame = (fcnt == 0).
  - The new value takes effect on the clock after frame_start; pixels in the frame_start cycle use the old value.
- Startup state machine, which flushes the buffer's power-on contents:
  - WAIT_FRAME (reset state): out forced to 0. Go to CLEAR on frame_start.
  - CLEAR: out forced to 0 for a full frame. Go to RUN on the next frame_start.
  - RUN: normal operation. Stays in RUN until reset.
  - Forcing applies at stage 2, using the state registered at stage 1 so the forcing stays aligned with the data.
- Reset (asynchronous, any time, including mid-line):
  - All pipeline registers and outputs go to 0.
  - pixel_out_valid = 0, fcnt = 0, state = WAIT_FRAME.
  - Release is synchronous to clock.
- Simultaneous frame_start and hit: the hit is processed normally; the state transition happens at the next clock.
- Saturation:
  - All arithmetic is done at PIXEL_W+1 bits, then clamped to the range 0..2^PIXEL_W−1.
  - hit_intensity = 0 with hit_valid = 1 is legal and leaves d unchanged.

Optional Feature:
- PHOSPHOR_ADDITIVE_HIT_EN defined: merge becomes out = sat(d + hit_intensity), so repeated hits brighten a pixel toward full scale.
- Undefined: max() merge as above.
- Latency, blanking and state machine are identical in both builds.

Decomposition:
- Package `phosphor_pkg`: PIXEL_W, the state encoding (WAIT_FRAME = 2'd0, CLEAR = 2'd1, RUN = 2'd2), and the saturating-add and max function definitions.
- One sub-module `phosphor_decay_alu`: a combinational decay+merge datapath, with inputs tap, decay_frame, hit_valid, hit_intensity and output result. The top-level module owns the pipeline, fcnt and the state machine.

Test Plan:
- Reset then two frame_start pulses: all outputs 0 through WAIT_FRAME and CLEAR; the first RUN pixel with tap_in = 0x80, decay frame, no hit gives 0x70 exactly 2 clocks later.
- Decay floor, in RUN on a decay frame: tap_in 0x05 → 0x04; 0x01 → 0x00; 0x00 → 0x00.
- DECAY_PERIOD = 2: tap_in 0x40 held while counting frames gives 0x38 on even frames and 0x40 on odd frames. A frame_start cycle still uses the previous frame's rule.
- Hit merge, without the macro: tap 0x20, hit 0x90 → 0x90; tap 0xA0 (decayed to 0x8C), hit 0x50 → 0x8C.
- Hit merge, with PHOSPHOR_ADDITIVE_HIT_EN: decayed 0x8C + hit 0x90 → 0xFF (saturated); tap 0x00 + hit 0x10 → 0x10.
- active = 0 with hit_valid = 1 and tap 0xFF → out 0x00, pixel_out_valid 0. Then assert reset_n low mid-line → outputs 0 immediately, and the block re-enters WAIT_FRAME.
